// File: rtl/tt_sweep_driver.sv
// tt_sweep_driver
//
// Walks a combinational exercise block through every input code
// 0..2^N_IN-1. For each code the driver holds stim steady for SETTLE
// cycles, then samples resp. It streams the captured vector out and
// folds it into a 16-bit MISR, so one compare checks the whole table.
//
// Ports
//   clk        : system clock, rising edge
//   reset      : asynchronous, active-high reset
//   start      : one-cycle sweep request (only honoured while idle)
//   resp       : response from the block under test
//   stim       : stimulus code driven to the block under test
//   busy       : high while a sweep is in progress
//   done       : high from end of sweep until the next accepted start
//   vec_valid  : one-cycle pulse, vec_idx/vec_resp carry a new vector
//   vec_idx    : stim code of the captured vector
//   vec_resp   : resp captured for vec_idx
//   signature  : MISR result, valid while done=1
//
// Optional build macro TT_SWEEP_ERRCNT_EN adds:
//   exp_resp   : expected response for the current stim (combinational)
//   err_cnt    : number of sampled mismatches in the current/last sweep
//   err_flag   : sticky mismatch flag, cleared by reset or accepted start
module tt_sweep_driver #(
  parameter int N_IN   = 5,
  parameter int N_OUT  = 8,
  parameter int SETTLE = 2,   // 1..15
  parameter int SIG_W  = 16   // MISR taps below are fixed for 16 bits
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [N_OUT-1:0] resp,
`ifdef TT_SWEEP_ERRCNT_EN
  input  logic [N_OUT-1:0] exp_resp,
  output logic [N_IN:0]    err_cnt,
  output logic             err_flag,
`endif
  output logic [N_IN-1:0]  stim,
  output logic             busy,
  output logic             done,
  output logic             vec_valid,
  output logic [N_IN-1:0]  vec_idx,
  output logic [N_OUT-1:0] vec_resp,
  output logic [SIG_W-1:0] signature
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_SAMPLE = 2'd2;

  localparam logic [3:0]      SETTLE_LD = 4'(SETTLE);
  localparam logic [N_IN-1:0] LAST_CODE = {N_IN{1'b1}};

  logic [1:0]       state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [N_IN-1:0]  stim_q, stim_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             vv_q, vv_d;
  logic [N_IN-1:0]  idx_q, idx_d;
  logic [N_OUT-1:0] vresp_q, vresp_d;
  logic [SIG_W-1:0] sig_q, sig_d;

  // MISR step: x^16+x^15+x^13+x^4+1, response folded into the low bits.
  logic             misr_fb;
  logic [SIG_W-1:0] resp_ext;
  assign misr_fb  = sig_q[15] ^ sig_q[14] ^ sig_q[12] ^ sig_q[3];
  assign resp_ext = {{(SIG_W-N_OUT){1'b0}}, resp};

`ifdef TT_SWEEP_ERRCNT_EN
  logic [N_IN:0] err_cnt_q, err_cnt_d;
  logic          err_flag_q, err_flag_d;
`endif

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    stim_d  = stim_q;
    busy_d  = busy_q;
    done_d  = done_q;
    vv_d    = 1'b0;
    idx_d   = idx_q;
    vresp_d = vresp_q;
    sig_d   = sig_q;
`ifdef TT_SWEEP_ERRCNT_EN
    err_cnt_d  = err_cnt_q;
    err_flag_d = err_flag_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          stim_d  = '0;
          cnt_d   = SETTLE_LD;
          sig_d   = '1;
          busy_d  = 1'b1;
          done_d  = 1'b0;
          state_d = ST_WAIT;
`ifdef TT_SWEEP_ERRCNT_EN
          err_cnt_d  = '0;
          err_flag_d = 1'b0;
`endif
        end
      end
      ST_WAIT: begin
        // Leaving on cnt==1 gives exactly SETTLE stable WAIT cycles.
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = ST_SAMPLE;
        end
      end
      ST_SAMPLE: begin
        vresp_d = resp;
        idx_d   = stim_q;
        vv_d    = 1'b1;
        sig_d   = {sig_q[SIG_W-2:0], misr_fb} ^ resp_ext;
`ifdef TT_SWEEP_ERRCNT_EN
        if (resp != exp_resp) begin
          err_cnt_d  = err_cnt_q + (N_IN+1)'(1);
          err_flag_d = 1'b1;
        end
`endif
        if (stim_q == LAST_CODE) begin
          // Hold the last code rather than wrapping.
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          stim_d  = stim_q + N_IN'(1);
          cnt_d   = SETTLE_LD;
          state_d = ST_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      stim_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      vv_q    <= 1'b0;
      idx_q   <= '0;
      vresp_q <= '0;
      sig_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      stim_q  <= stim_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      vv_q    <= vv_d;
      idx_q   <= idx_d;
      vresp_q <= vresp_d;
      sig_q   <= sig_d;
    end
  end

`ifdef TT_SWEEP_ERRCNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      err_cnt_q  <= '0;
      err_flag_q <= 1'b0;
    end else begin
      err_cnt_q  <= err_cnt_d;
      err_flag_q <= err_flag_d;
    end
  end

  assign err_cnt  = err_cnt_q;
  assign err_flag = err_flag_q;
`endif

  assign stim      = stim_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign vec_valid = vv_q;
  assign vec_idx   = idx_q;
  assign vec_resp  = vresp_q;
  assign signature = sig_q;

endmodule

// File: tb/tb_tt_sweep_driver.sv
// Bench for tt_sweep_driver. Instance A runs with SETTLE=2 and a random
// response table, and is checked every cycle against a timing/MISR model.
// Instance B runs with SETTLE=1 and resp tied to zero.
module tb_tt_sweep_driver;

  localparam int NV  = 32;
  localparam int S_A = 2;
  localparam int S_B = 1;
  localparam int L_A = NV * (S_A + 1);

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_a = 1'b0, start_b = 1'b0;
  logic [7:0]  resp_a, resp_b;
  logic [4:0]  stim_a, stim_b, vidx_a, vidx_b;
  logic        busy_a, busy_b, done_a, done_b, vv_a, vv_b;
  logic [7:0]  vresp_a, vresp_b;
  logic [15:0] sig_a, sig_b;

  logic [7:0]  tbl [NV];
  logic [15:0] sig_tbl [NV+1];

  int  n_checks = 0;
  int  n_fail = 0;
  bit  cmp_en = 1'b0;

  always #5 clk = ~clk;

  assign resp_a = tbl[stim_a];
  assign resp_b = 8'h00;

`ifdef TT_SWEEP_ERRCNT_EN
  logic [7:0] exp_a;
  logic [5:0] errc_a, errc_b;
  logic       errf_a, errf_b;
  assign exp_a = (stim_a == 5'd7 || stim_a == 5'd20) ? ~tbl[stim_a] : tbl[stim_a];
`endif

  tt_sweep_driver #(.N_IN(5), .N_OUT(8), .SETTLE(S_A), .SIG_W(16)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .resp(resp_a),
`ifdef TT_SWEEP_ERRCNT_EN
    .exp_resp(exp_a), .err_cnt(errc_a), .err_flag(errf_a),
`endif
    .stim(stim_a), .busy(busy_a), .done(done_a), .vec_valid(vv_a),
    .vec_idx(vidx_a), .vec_resp(vresp_a), .signature(sig_a)
  );

  tt_sweep_driver #(.N_IN(5), .N_OUT(8), .SETTLE(S_B), .SIG_W(16)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .resp(resp_b),
`ifdef TT_SWEEP_ERRCNT_EN
    .exp_resp(8'h00), .err_cnt(errc_b), .err_flag(errf_b),
`endif
    .stim(stim_b), .busy(busy_b), .done(done_b), .vec_valid(vv_b),
    .vec_idx(vidx_b), .vec_resp(vresp_b), .signature(sig_b)
  );

  function automatic logic [15:0] misr(input logic [15:0] s, input logic [7:0] r);
    logic fb;
    fb = s[15] ^ s[14] ^ s[12] ^ s[3];
    return {s[14:0], fb} ^ {8'h00, r};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, req, $time);
    end
  endtask

  task automatic new_table();
    for (int i = 0; i < NV; i++) tbl[i] = 8'($urandom_range(0, 255));
    sig_tbl[0] = 16'hFFFF;
    for (int i = 0; i < NV; i++) sig_tbl[i+1] = misr(sig_tbl[i], tbl[i]);
  endtask

  // Model of instance A: n_m = clock edges since the last accepted start.
  bit act_m;
  int n_m;
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      act_m <= 1'b0;
      n_m   <= 0;
    end else if (start_a && !(act_m && n_m < L_A)) begin
      act_m <= 1'b1;
      n_m   <= 0;
    end else if (act_m) begin
      n_m <= n_m + 1;
    end
  end

  task automatic cycle_check();
    int k;
    logic [4:0]  e_stim;
    logic        e_busy, e_done, e_vv;
    logic [15:0] e_sig;
    k = 0; e_stim = 5'd0; e_busy = 1'b0; e_done = 1'b0; e_vv = 1'b0; e_sig = 16'h0;
    if (act_m) begin
      k = n_m / (S_A + 1);
      if (k > NV) k = NV;
      e_busy = (n_m < L_A);
      e_done = !e_busy;
      e_stim = e_busy ? 5'(k) : 5'd31;
      e_vv   = (n_m > 0) && (n_m % (S_A + 1) == 0) && (n_m <= L_A);
      e_sig  = sig_tbl[k];
    end
    chk("stim", 32'(stim_a), 32'(e_stim));
    chk("busy", 32'(busy_a), 32'(e_busy));
    chk("done", 32'(done_a), 32'(e_done));
    chk("vec_valid", 32'(vv_a), 32'(e_vv));
    chk("signature", 32'(sig_a), 32'(e_sig));
    if (e_vv) begin
      chk("vec_idx", 32'(vidx_a), 32'(k - 1));
      chk("vec_resp", 32'(vresp_a), 32'(tbl[k-1]));
    end
`ifdef TT_SWEEP_ERRCNT_EN
    chk("err_cnt", 32'(errc_a), act_m ? 32'(int'(k > 7) + int'(k > 20)) : 32'd0);
    chk("err_flag", 32'(errf_a), act_m ? 32'(k > 7) : 32'd0);
`endif
  endtask

  always @(posedge clk) begin
    #1;
    if (cmp_en) cycle_check();
  end

  // Runs one sweep on A (sel=0) or B (sel=1); optionally re-pulses start
  // once restart_at vectors have been seen.
  task automatic run_sweep(input bit sel, input int restart_at,
                           output int cyc, output int pulses, output int busy_n, output int nz);
    bit pend;
    pend = 1'b0;
    @(negedge clk);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk); #1;
    busy_n = int'(sel ? busy_b : busy_a);
    cyc = 0; pulses = 0; nz = 0;
    @(negedge clk);
    start_a = 1'b0; start_b = 1'b0;
    while (cyc < 400) begin
      @(posedge clk); #1;
      cyc++;
      if (pend) begin start_a = 1'b0; pend = 1'b0; end
      if (sel ? vv_b : vv_a) begin
        pulses++;
        if ((sel ? vresp_b : vresp_a) != 8'h00) nz++;
        if (pulses == restart_at) begin start_a = 1'b1; pend = 1'b1; end
      end
      if (sel ? busy_b : busy_a) busy_n++;
      if (sel ? done_b : done_a) break;
    end
  endtask

  initial begin
    int cyc, pulses, busy_n, nz, ndone, dbl, guard;
    logic [15:0] first_sig, lfsr;
    bit prev_done;

    new_table();
    repeat (3) @(posedge clk);
    #1;
    chk("rst_stim", 32'(stim_a), 0);
    chk("rst_busy", 32'(busy_a), 0);
    chk("rst_done", 32'(done_a), 0);
    chk("rst_sig", 32'(sig_a), 0);
    chk("rst_sig_b", 32'(sig_b), 0);
    @(negedge clk);
    reset = 1'b0;
    cmp_en = 1'b1;

    // Hand-computed MISR steps pin the model.
    chk("misr_ffff", 32'(misr(16'hFFFF, 8'h00)), 32'h0000FFFE);
    chk("misr_8000", 32'(misr(16'h8000, 8'h00)), 32'h00000001);
    chk("misr_a5",   32'(misr(16'h0000, 8'hA5)), 32'h000000A5);

    // Plain sweep on A.
    run_sweep(1'b0, -1, cyc, pulses, busy_n, nz);
    chk("t1_done_latency", 32'(cyc), 96);
    chk("t1_pulses", 32'(pulses), 32);
    chk("t1_busy_cycles", 32'(busy_n), 96);
    chk("t1_sig", 32'(sig_a), 32'(sig_tbl[NV]));
`ifdef TT_SWEEP_ERRCNT_EN
    chk("t6_err_cnt", 32'(errc_a), 2);
    chk("t6_err_flag", 32'(errf_a), 1);
`endif

    // SETTLE=1 with zero response: pure LFSR.
    run_sweep(1'b1, -1, cyc, pulses, busy_n, nz);
    lfsr = 16'hFFFF;
    for (int i = 0; i < NV; i++) lfsr = misr(lfsr, 8'h00);
    chk("t2_done_latency", 32'(cyc), 64);
    chk("t2_pulses", 32'(pulses), 32);
    chk("t2_nonzero_resp", 32'(nz), 0);
    chk("t2_sig", 32'(sig_b), 32'(lfsr));

    // start during a sweep is ignored.
    new_table();
    run_sweep(1'b0, 11, cyc, pulses, busy_n, nz);
    chk("t3_pulses", 32'(pulses), 32);
    chk("t3_done_latency", 32'(cyc), 96);
    chk("t3_sig", 32'(sig_a), 32'(sig_tbl[NV]));

    // Asynchronous reset in the middle of vector 17.
    new_table();
    @(negedge clk); start_a = 1'b1;
    @(negedge clk); start_a = 1'b0;
    guard = 0;
    while (stim_a != 5'd17 && guard < 200) begin @(posedge clk); #1; guard++; end
    chk("t4_reach17", 32'(stim_a), 17);
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    chk("t4_stim", 32'(stim_a), 0);
    chk("t4_busy", 32'(busy_a), 0);
    chk("t4_done", 32'(done_a), 0);
    chk("t4_vv", 32'(vv_a), 0);
    chk("t4_sig", 32'(sig_a), 0);
    chk("t4_vidx", 32'(vidx_a), 0);
    @(negedge clk); reset = 1'b0;
    run_sweep(1'b0, -1, cyc, pulses, busy_n, nz);
    chk("t4_done_latency", 32'(cyc), 96);
    chk("t4_pulses", 32'(pulses), 32);

    // start held high: back-to-back sweeps.
    new_table();
    @(negedge clk); start_a = 1'b1;
    ndone = 0; dbl = 0; prev_done = 1'b0; first_sig = 16'h0;
    for (int i = 0; i < 250; i++) begin
      @(posedge clk); #1;
      if (done_a) begin
        if (prev_done) dbl++;
        if (ndone == 0) first_sig = sig_a;
        else chk("t5_sig_repeat", 32'(sig_a), 32'(first_sig));
        chk("t5_sig", 32'(sig_a), 32'(sig_tbl[NV]));
        ndone++;
      end
      prev_done = done_a;
    end
    chk("t5_done_count", 32'(ndone), 2);
    chk("t5_done_width", 32'(dbl), 0);
    @(negedge clk); start_a = 1'b0;
    guard = 0;
    while (!done_a && guard < 200) begin @(posedge clk); #1; guard++; end
    chk("t5_final_done", 32'(done_a), 1);

    repeat (3) @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tt_sweep_driver.md
Name: tt_sweep_driver

Overview:
Sequential stimulus/response driver for the combinational truth-table exercise blocks in the practice set.
- Applies every input code 0..2^N_IN-1, in order, to the block under test.
- Waits a programmable settle time for each code, then samples the block's outputs.
- Streams each captured vector out and folds all responses into a MISR signature, so a single compare checks the whole table.
- Sits between a board/bench controller and any 5-input exercise block; it is the initiator side of that block's input/output interface.

Parameters:
N_IN, 5, stimulus width; stim[4]=A ... stim[0]=E
N_OUT, 8, response width; resp = {a1,a2,b1,b2,c1,c2,d1,d2}
SETTLE, 2, cycles stim is held stable before sampling; legal range 1..15
SIG_W, 16, signature width (fixed polynomial below, SIG_W=16 only)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  one-cycle request to begin a sweep; sampled in IDLE only
resp  in  N_OUT  response from the block under test
stim  out  N_IN  stimulus to the block under test
busy  out  1  high while a sweep is in progress
done  out  1  high from end of sweep until the next accepted start
vec_valid  out  1  one-cycle pulse: vec_idx/vec_resp hold a new captured vector
vec_idx  out  N_IN  stim code of the captured vector
vec_resp  out  N_OUT  resp captured for vec_idx
signature  out  SIG_W  MISR result; valid when done=1

Behaviour:
- Reset (async, immediate): all outputs 0, FSM=IDLE, settle counter 0. Reset during a sweep abandons it; done stays 0.
- FSM states: IDLE, WAIT, SAMPLE.
- IDLE:
  - start=1 → at the next edge: stim=0, cnt=SETTLE, signature=16'hFFFF, busy=1, done=0, go to WAIT.
  - done keeps its value in IDLE.
- WAIT:
  - cnt decrements each cycle.
  - When cnt==1 → go to SAMPLE.
  - stim is therefore stable for exactly SETTLE WAIT cycles.
- SAMPLE (one cycle). At its closing edge:
  - vec_resp<=resp, vec_idx<=stim, vec_valid<=1 for the next cycle only.
  - signature<={sig[14:0],fb} ^ {{(16-N_OUT){1'b0}},resp}, with fb=sig[15]^sig[14]^sig[12]^sig[3] (x^16+x^15+x^13+x^4+1).
  - If stim==2^N_IN-1: go to IDLE, busy<=0, done<=1, stim held at last code.
  - Otherwise: stim<=stim+1, cnt<=SETTLE, go to WAIT.
- Timing:
  - Each vector takes SETTLE+1 cycles.
  - done rises 2^N_IN*(SETTLE+1) cycles after the start-accepting edge: 96 for the defaults.
  - The last vec_valid pulse coincides with the first done=1 cycle.
- start while busy=1 is ignored; it is not queued.
- start held high continuously: a new sweep begins the cycle after done rises, and done drops again.
- stim never wraps within a sweep. Exactly 2^N_IN vec_valid pulses per sweep, vec_idx strictly increasing from 0.
- signature is not updated outside SAMPLE.

Optional Feature:
Macro TT_SWEEP_ERRCNT_EN.
- Defined:
  - Adds input exp_resp[N_OUT-1:0]: expected response for the current stim, supplied combinationally (e.g. golden ROM addressed by stim).
  - Adds outputs err_cnt[N_IN:0] and err_flag.
  - In SAMPLE, if resp!=exp_resp: err_cnt increments and err_flag sets.
  - Both clear on reset and on an accepted start. err_flag is sticky until then.
  - Counter capacity covers 2^N_IN mismatches without overflow.
- Not defined: these ports and their logic are absent; all other behaviour is identical.

Test Plan:
1. Defaults, resp driven by a model of the exercise equations, start pulsed once → 32 vec_valid pulses with vec_idx 0..31; busy high 96 cycles; done at cycle 96; signature equals the reference-model MISR value.
2. SETTLE=1, resp tied 8'h00 → 64 cycles to done; signature equals 32 pure LFSR shifts from 16'hFFFF; every vec_resp=0.
3. start pulsed again at vector 10 of a sweep → no restart; vec_idx continues 11..31; exactly 32 pulses total.
4. Async reset asserted mid-cycle at vector 17 → stim, busy, done, vec_valid and signature are 0 immediately without a clock edge; a new start gives a full sweep from stim=0.
5. start held high for 250 cycles → back-to-back sweeps; done high for exactly one cycle between sweeps; the signature from each sweep is identical.
6. TT_SWEEP_ERRCNT_EN defined, exp_resp=resp except at stim=7 and stim=20 → err_cnt=2 and err_flag=1 at done; both clear on the next start.
